// File: rtl/pcie_phy_pkg.sv
// PCIe PHY shared types and constants.
// Used by the RX sync header checker and the TX sync header generator.
package pcie_phy_pkg;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKING  = 2'd1,
      LOCKED   = 2'd2
   } blk_lock_state_t;

   localparam logic [1:0] SYNC_HDR_DATA = 2'b01;
   localparam logic [1:0] SYNC_HDR_OS   = 2'b10;

   function automatic logic hdr_valid(input logic [1:0] h);
      return (h == SYNC_HDR_DATA) || (h == SYNC_HDR_OS);
   endfunction

endpackage

// File: rtl/pcie_blk_err_win.sv
// Locked-state error window: counts invalid headers per ERR_WIN blocks.
// An error on the wrapping block is counted in the new window.
module pcie_blk_err_win #(
   parameter int ERR_WIN    = 64,
   parameter int ERR_THRESH = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic adv,
   input  logic err,
   output logic thresh_hit
);

   localparam int WW = $clog2(ERR_WIN);
   localparam int EW = $clog2(ERR_THRESH + 1);
   localparam logic [WW-1:0] WIN_LAST = WW'(ERR_WIN - 1);
   localparam logic [EW-1:0] ERR_LAST = EW'(ERR_THRESH - 1);

   logic [WW-1:0] win_cnt;
   logic [EW-1:0] err_cnt;
   logic          wrap;

   assign wrap       = (win_cnt == WIN_LAST);
   assign thresh_hit = adv && err && (err_cnt == ERR_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win_cnt <= '0;
         err_cnt <= '0;
      end else if (clr || thresh_hit) begin
         win_cnt <= '0;
         err_cnt <= '0;
      end else if (adv) begin
         win_cnt <= wrap ? '0 : win_cnt + 1'b1;
         err_cnt <= wrap ? EW'(err) : err_cnt + EW'(err);
      end
   end

endmodule

// File: rtl/pcie_sync_head_chk.sv
// RX sync header checker: validates 128b/130b headers, runs block lock,
// strips the header and forwards payload while locked.
module pcie_sync_head_chk
   import pcie_phy_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int LOCK_CNT   = 4,
   parameter int ERR_WIN    = 64,
   parameter int ERR_THRESH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH+1:0] data_in,
   input  logic                  data_in_valid,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_out_valid,
   output logic                  block_type,
   output logic                  sync_err,
   output logic                  slip_req,
   output logic                  block_lock
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);

   blk_lock_state_t state;
   blk_lock_state_t state_nx;

   logic [GW-1:0]         good_cnt;
   logic [GW-1:0]         good_nx;
   logic [1:0]            hdr;
   logic [DATA_WIDTH-1:0] payload;
   logic                  hdr_ok;
   logic                  adv;
   logic                  bad;
   logic                  thresh_hit;
   logic                  dov_d;
   logic                  se_d;
   logic                  sr_d;

   assign hdr     = data_in[DATA_WIDTH+1:DATA_WIDTH];
   assign payload = data_in[DATA_WIDTH-1:0];
   assign hdr_ok  = hdr_valid(hdr);
   assign adv     = data_in_valid && (state == LOCKED);
   assign bad     = data_in_valid && !hdr_ok;

   pcie_blk_err_win #(
      .ERR_WIN    (ERR_WIN),
      .ERR_THRESH (ERR_THRESH)
   ) u_err_win (
      .clk        (clk),
      .reset_n    (reset_n),
      .clr        (state != LOCKED),
      .adv        (adv),
      .err        (!hdr_ok),
      .thresh_hit (thresh_hit)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= UNLOCKED;
         good_cnt <= '0;
      end else begin
         state    <= state_nx;
         good_cnt <= good_nx;
      end
   end

   always_comb begin
      state_nx = state;
      good_nx  = good_cnt;
      if (data_in_valid) begin
         unique case (state)
            UNLOCKED: begin
               if (hdr_ok) begin
                  good_nx  = GW'(LOCK_CNT > 1);
                  state_nx = (LOCK_CNT == 1) ? LOCKED : LOCKING;
               end
            end
            LOCKING: begin
               if (!hdr_ok) begin
                  good_nx  = '0;
                  state_nx = UNLOCKED;
               end else if (good_cnt == GOOD_LAST) begin
                  good_nx  = '0;
                  state_nx = LOCKED;
               end else begin
                  good_nx = good_cnt + 1'b1;
               end
            end
            LOCKED: begin
               if (thresh_hit) state_nx = UNLOCKED;
            end
            default: begin
               good_nx  = '0;
               state_nx = UNLOCKED;
            end
         endcase
      end
   end

   // Slip only while hunting for alignment, never on lock loss.
   always_comb begin
      dov_d = adv && hdr_ok;
      se_d  = bad;
      sr_d  = bad && (state != LOCKED);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out       <= '0;
         block_type     <= 1'b0;
         data_out_valid <= 1'b0;
         sync_err       <= 1'b0;
         slip_req       <= 1'b0;
         block_lock     <= 1'b0;
      end else begin
         data_out_valid <= dov_d;
         sync_err       <= se_d;
         slip_req       <= sr_d;
         block_lock     <= (state_nx == LOCKED);
         if (dov_d) begin
            data_out   <= payload;
            block_type <= hdr[1];
         end
      end
   end

endmodule

// File: tb/tb_pcie_sync_head_chk.sv
// Directed bench for pcie_sync_head_chk.
// Flags are packed as {data_out_valid, block_type, sync_err, slip_req, block_lock}.
module tb_pcie_sync_head_chk;

   localparam int DW = 128;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [DW+1:0] data_in = '0;
   logic          data_in_valid = 1'b0;
   logic [DW-1:0] data_out;
   logic          data_out_valid;
   logic          block_type;
   logic          sync_err;
   logic          slip_req;
   logic          block_lock;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   pcie_sync_head_chk dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .block_type     (block_type),
      .sync_err       (sync_err),
      .slip_req       (slip_req),
      .block_lock     (block_lock)
   );

   typedef struct {
      logic [1:0]    hdr;
      logic [DW-1:0] pay;
      logic          vld;
      logic [4:0]    flags;
      logic          dchk;
      logic [DW-1:0] dexp;
   } vec_t;

   vec_t tbl [9];

   // block_type is only meaningful with data_out_valid
   task automatic chk(input string nm, input logic [4:0] exp,
                      input logic dchk, input logic [DW-1:0] dexp);
      logic [4:0] act;
      logic [4:0] m;
      act = {data_out_valid, block_type, sync_err, slip_req, block_lock};
      m = exp[4] ? 5'b11111 : 5'b10111;
      total++;
      if (((act & m) !== (exp & m)) || (dchk && (data_out !== dexp))) begin
         bad++;
         $display("FAIL %s: flags=%b data=%h expected flags=%b data=%h",
                  nm, act, data_out, exp, dexp);
      end
   endtask

   task automatic send(input logic [1:0] h, input logic [DW-1:0] p,
                       input logic v);
      data_in = {h, p};
      data_in_valid = v;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      data_in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset", 5'b00000, 1'b1, '0);
      reset_n = 1'b1;
   endtask

   task automatic lock_up();
      for (int i = 0; i < 4; i++) send(2'b01, DW'(100 + i), 1'b1);
      chk("lock_up", 5'b00001, 1'b0, '0);
   endtask

   initial begin
      logic [DW-1:0] a5;
      logic          e;
      a5 = {16{8'hA5}};

      tbl[0] = '{2'b01, DW'(1), 1'b1, 5'b00000, 1'b0, '0};
      tbl[1] = '{2'b01, DW'(2), 1'b1, 5'b00000, 1'b0, '0};
      tbl[2] = '{2'b01, DW'(3), 1'b1, 5'b00000, 1'b0, '0};
      tbl[3] = '{2'b01, DW'(4), 1'b1, 5'b00001, 1'b0, '0};
      tbl[4] = '{2'b01, DW'(5), 1'b1, 5'b10001, 1'b1, DW'(5)};
      tbl[5] = '{2'b10, a5,     1'b1, 5'b11001, 1'b1, a5};
      tbl[6] = '{2'b01, DW'(7), 1'b0, 5'b00001, 1'b1, a5};
      tbl[7] = '{2'b11, DW'(8), 1'b1, 5'b00101, 1'b1, a5};
      tbl[8] = '{2'b01, DW'(9), 1'b1, 5'b10001, 1'b1, DW'(9)};

      @(negedge clk);
      do_reset();
      for (int i = 0; i < 9; i++) begin
         send(tbl[i].hdr, tbl[i].pay, tbl[i].vld);
         chk($sformatf("tbl%0d", i), tbl[i].flags, tbl[i].dchk, tbl[i].dexp);
      end

      // invalid headers while unlocked: slip and error pulse each time
      do_reset();
      for (int i = 0; i < 3; i++) begin
         send(2'b00, DW'(i), 1'b1);
         chk("unl_bad", 5'b00110, 1'b0, '0);
         send(2'b01, DW'(i), 1'b0);
         chk("unl_idle", 5'b00000, 1'b0, '0);
      end

      // error during LOCKING restarts the lock count
      do_reset();
      send(2'b01, DW'(1), 1'b1);
      send(2'b01, DW'(2), 1'b1);
      chk("lk_two", 5'b00000, 1'b0, '0);
      send(2'b11, DW'(3), 1'b1);
      chk("lk_bad", 5'b00110, 1'b0, '0);
      for (int i = 0; i < 3; i++) begin
         send(2'b01, DW'(i), 1'b1);
         chk("lk_again", 5'b00000, 1'b0, '0);
      end
      send(2'b10, DW'(9), 1'b1);
      chk("lk_fourth", 5'b00001, 1'b0, '0);
      send(2'b01, DW'(10), 1'b1);
      chk("lk_fwd", 5'b10001, 1'b1, DW'(10));

      // four errors within one window drop lock without a slip
      do_reset();
      lock_up();
      for (int k = 0; k <= 50; k++) begin
         e = (k == 5) || (k == 20) || (k == 40) || (k == 50);
         send(e ? 2'b11 : 2'b01, DW'(k), 1'b1);
         if (k == 50) chk("win_loss", 5'b00100, 1'b0, '0);
         else if (e) chk("win_err", 5'b00101, 1'b0, '0);
         else chk("win_good", 5'b10001, 1'b1, DW'(k));
      end
      send(2'b01, DW'(77), 1'b1);
      chk("after_loss", 5'b00000, 1'b0, '0);

      // 3 errors per window held; error on the wrap block counts forward
      do_reset();
      lock_up();
      for (int w = 0; w < 4; w++) begin
         for (int k = 0; k < 64; k++) begin
            e = (k == 10) || (k == 30) || ((k == 50) && (w < 3))
              || ((k == 63) && (w == 3));
            send(e ? 2'b11 : 2'b01, DW'(w * 64 + k), 1'b1);
            if (e) chk("hold_err", 5'b00101, 1'b0, '0);
            else chk("hold_good", 5'b10001, 1'b1, DW'(w * 64 + k));
         end
      end
      for (int k = 0; k < 8; k++) begin
         e = (k >= 5);
         send(e ? 2'b11 : 2'b01, DW'(1000 + k), 1'b1);
         if (k == 7) chk("wrap_loss", 5'b00100, 1'b0, '0);
         else if (e) chk("wrap_err", 5'b00101, 1'b0, '0);
         else chk("wrap_good", 5'b10001, 1'b1, DW'(1000 + k));
      end

      // async reset mid-window while locked
      do_reset();
      lock_up();
      for (int k = 0; k < 10; k++) send(2'b01, DW'(k + 1), 1'b1);
      chk("pre_rst", 5'b10001, 1'b1, DW'(10));
      data_in = {2'b10, a5};
      data_in_valid = 1'b1;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1 chk("rst_async", 5'b00000, 1'b1, '0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         data_in_valid = ~data_in_valid;
         @(posedge clk);
         #1 chk("rst_hold", 5'b00000, 1'b1, '0);
      end
      @(negedge clk);
      data_in_valid = 1'b0;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(2'b01, DW'(i), 1'b1);
         chk("relock_wait", 5'b00000, 1'b0, '0);
      end
      send(2'b01, DW'(3), 1'b1);
      chk("relock", 5'b00001, 1'b0, '0);
      send(2'b10, DW'(4), 1'b1);
      chk("relock_fwd", 5'b11001, 1'b1, DW'(4));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pcie_sync_head_chk.md
Name: pcie_sync_head_chk

Overview:
- RX-side counterpart of the TX sync header generator in the PCIe PHY.
- Takes 130-bit blocks laid out as {sync_header[1:0], payload[127:0]} from the RX deserializer/aligner.
- Checks each sync header (2'b01 = data block, 2'b10 = ordered set) and runs the block-lock state machine.
- Strips the header and forwards the payload plus block type to the RX descrambler. Requests a bit slip from the aligner while unlocked.

Parameters:
- DATA_WIDTH, 128, payload width per block.
- LOCK_CNT, 4, consecutive valid headers required to reach lock (>=1).
- ERR_WIN, 64, window length in accepted blocks for error counting while locked (>=2).
- ERR_THRESH, 4, invalid headers within one window that cause loss of lock (>=1).

Ports:
- clk  input  1  block clock.
- reset_n  input  1  asynchronous active-low reset.
- data_in  input  DATA_WIDTH+2  {sync_header, payload}; header in the MSBs.
- data_in_valid  input  1  data_in holds a block this cycle.
- data_out  output  DATA_WIDTH  payload with the header stripped.
- data_out_valid  output  1  data_out holds a valid block, forwarded only while locked.
- block_type  output  1  0 = data block (hdr 01), 1 = ordered set (hdr 10); qualified by data_out_valid.
- sync_err  output  1  1-cycle pulse: an invalid header (00/11) was received.
- slip_req  output  1  1-cycle pulse asking the aligner to slip one bit.
- block_lock  output  1  level; high while the state is LOCKED.

Behaviour:
- Reset (async, reset_n=0):
  - State = UNLOCKED; good_cnt, err_cnt and win_cnt = 0.
  - All outputs = 0, including data_out.
- Outputs are registered, with 1-cycle latency from an accepted data_in.
- hdr = data_in[DATA_WIDTH+1:DATA_WIDTH]. hdr_ok = (hdr==2'b01) or (hdr==2'b10).
- data_in_valid=0 cycle:
  - No state or counter change.
  - data_out_valid, sync_err and slip_req = 0 next cycle.
  - data_out holds its last value.
- State UNLOCKED:
  - hdr_ok -> good_cnt=1 and go to LOCKING; go directly to LOCKED if LOCK_CNT==1.
  - !hdr_ok -> sync_err=1, slip_req=1, stay in UNLOCKED.
- State LOCKING:
  - hdr_ok -> good_cnt+1. On reaching LOCK_CNT go to LOCKED and clear err_cnt and win_cnt.
  - !hdr_ok -> sync_err=1, slip_req=1, good_cnt=0, go to UNLOCKED.
- State LOCKED:
  - Every accepted block advances win_cnt. At win_cnt==ERR_WIN-1 it wraps to 0 and err_cnt restarts.
  - hdr_ok -> data_out=payload, block_type=hdr[1], data_out_valid=1.
  - !hdr_ok -> sync_err=1 and data_out_valid=0 (the block is dropped). err_cnt+1.
  - If err_cnt+1 == ERR_THRESH: go to UNLOCKED, clear all counters, no slip_req on this transition.
  - Window wrap on the same cycle as an error: err_cnt loads 1, i.e. the error counts in the new window. Lock loss takes precedence over the wrap.
- block_lock = (state==LOCKED), registered. It rises the cycle after the LOCK_CNT-th good header and falls the cycle after the threshold error.
- Blocks received in UNLOCKED/LOCKING are never forwarded, including the block that completes lock. The first forwarded block is the next one.
- Counter widths: $clog2(LOCK_CNT+1), $clog2(ERR_THRESH+1), $clog2(ERR_WIN). No overflow is possible.
- Reset asserted mid-stream: immediate return to the reset state. Upstream data is ignored until reset_n deasserts.

Decomposition:
- Package pcie_phy_pkg:
  - typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} blk_lock_state_t.
  - Constants SYNC_HDR_DATA = 2'b01 and SYNC_HDR_OS = 2'b10, shared with the TX sync header generator.
- One natural sub-module: pcie_blk_err_win, holding the win_cnt/err_cnt window counter. It outputs thresh_hit and is cleared by the FSM.

Test Plan:
- Reset, then 4 blocks with hdr 01 (payload i) -> block_lock rises the cycle after block 4. data_out_valid stays 0 through block 4 and is 1 for block 5 with data_out = block 5 payload and block_type = 0.
- Locked, send hdr 10 with payload 128'hA5..A5 -> 1 cycle later data_out = A5..A5, block_type = 1, data_out_valid = 1.
- Unlocked, send hdr 00 three times -> sync_err and slip_req each pulse 3 times, block_lock stays 0.
- LOCKING after 2 good blocks, send hdr 11 -> slip_req pulse, back to UNLOCKED. 4 more good blocks are needed to lock.
- Locked, 4 hdr 11 blocks among 60 good ones within one 64-block window -> block_lock falls the cycle after the 4th error, no slip_req on that cycle. 3 errors per window across 3 windows -> lock is held.
- Assert reset_n=0 mid-window while locked and while data_in_valid toggles -> all outputs 0 immediately. After release, re-lock takes exactly LOCK_CNT good blocks.
